scan_chain_ctrl: RTL
====================

// Module: scan_chain_ctrl
// PURPOSE
//  On-chip initiator for the my_reg scan chain: drives test_mode/scan_en/scan_in0 and samples scan_out0.
//  One start pulse runs a full scan cycle:
//   - shift in a CHAIN_LEN-bit pattern;
//   - pulse one functional capture clock;
//   - shift out the captured response and, optionally, compare it against an expected vector.
//  Sits between the test-access logic and my_reg, on the same clk as the chain.
// PARAMETERS
//  CHAIN_LEN  32  number of scan flops in the chain (>=2)
//  CNT_W      6   bit-counter width; must satisfy 2**CNT_W > CHAIN_LEN
// PORTS
//  clk        in   1          system clock, all logic on posedge
//  reset      in   1          synchronous, active-high
//  start      in   1          1-cycle request; sampled only in IDLE
//  pattern    in   CHAIN_LEN  stimulus vector; latched when start is accepted
//  expect     in   CHAIN_LEN  expected response; latched when start is accepted
//  mask       in   CHAIN_LEN  1 = compare this bit; latched when start is accepted
//  scan_out0  in   1          chain tail, from my_reg
//  scan_in0   out  1          chain head, to my_reg
//  scan_en    out  1          1 = shift, 0 = functional/capture
//  test_mode  out  1          held high for the whole operation
//  busy       out  1          high from start acceptance to the end of DONE
//  done       out  1          1-cycle pulse in DONE
//  captured   out  CHAIN_LEN  response vector; held until next start
//  pass       out  1          1 = no unmasked mismatch; valid while done=1, held after
//  fail_count out  CNT_W      number of unmasked mismatching bits
// BEHAVIOUR
//  Reset values: every output is 0 (scan_in0, scan_en, test_mode, busy, done, captured, pass, fail_count).
//  States: IDLE -> SHIFT_IN -> CAPTURE -> SHIFT_OUT -> DONE -> IDLE.
//  IDLE
//   - start=1: latch pattern/expect/mask; clear bit counter and fail_count; go SHIFT_IN.
//   - busy and test_mode rise on the next cycle.
//  SHIFT_IN
//   - Exactly CHAIN_LEN cycles with scan_en=1.
//   - scan_in0 = pattern[k] on cycle k (k=0..CHAIN_LEN-1), LSB first.
//  CAPTURE
//   - Exactly 1 cycle with scan_en=0 and scan_in0=0; the chain captures its functional data.
//  SHIFT_OUT
//   - Exactly CHAIN_LEN cycles with scan_en=1 and scan_in0=0.
//   - On cycle k, scan_out0 is sampled at the posedge that ends the cycle and stored in captured[k].
//   - So the first bit shifted in during SHIFT_IN returns in captured[0].
//  DONE
//   - done=1 for 1 cycle; scan_en=0; then go IDLE.
//   - test_mode and busy drop on the following cycle.
//  Latency: start to done = 2*CHAIN_LEN + 3 cycles (start edge included).
//  Counter: bit counter runs 0..CHAIN_LEN-1 and clears on each state exit; it never wraps inside a state.
//  start while busy is ignored: no queuing, no effect on the latched vectors.
//  start on the same cycle as DONE is ignored; start in the first IDLE cycle after DONE is accepted.
//  pattern/expect/mask changing while busy has no effect.
//  Reset asserted mid-operation: next cycle is IDLE with all outputs at reset values; the partial capture is discarded.
// CONFIGURATION
//  SCAN_COMPARE_EN defined:
//   - During SHIFT_OUT, each bit with mask[k]=1 and scan_out0!=expect[k] increments fail_count (saturating at all-ones).
//   - pass = (fail_count==0).
//  SCAN_COMPARE_EN undefined:
//   - expect/mask are unused; no compare logic is built.
//   - pass=1 and fail_count=0 from the first DONE onward.
//   - Both are 0 after reset.
// TESTING (CHAIN_LEN=8; bench model = 8-flop shift chain, capture loads ~chain)
//  1. Reset, no start for 20 cycles -> all outputs 0, scan_en never 1.
//  2. start, pattern=8'hA5 -> scan_in0 bits 1,0,1,0,0,1,0,1 on consecutive cycles;
//     done exactly 19 cycles after start; captured=8'h5A.
//  3. [COMPARE_EN] pattern=8'hA5, expect=8'h5A, mask=8'hFF -> pass=1, fail_count=0;
//     expect=8'h5B -> pass=0, fail_count=1; same with mask=8'hFE -> pass=1.
//  4. start pulsed again at cycles 3 and 10 after acceptance -> ignored;
//     exactly one done pulse; captured equals the first request's result.
//  5. reset asserted in SHIFT_OUT cycle 4 -> next cycle scan_en=0, test_mode=0, busy=0, captured=0;
//     a new start afterwards completes normally in 19 cycles.
//  6. Back-to-back: start in the cycle after done, pattern=8'hFF -> accepted; captured=8'h00.

Source files
------------

// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: on-chip initiator for the my_reg scan chain.
// One start pulse shifts a pattern in (LSB first), pulses one capture cycle,
// then shifts the response out into `captured`.
// Optional feature macro: SCAN_COMPARE_EN adds a masked compare of the
// response against an expected vector (pass / fail_count). Without it,
// expect_vec and mask are ignored, and pass reads 1 from the first DONE.
// Note: the expected-vector port is named expect_vec because `expect` is a
// reserved word in SystemVerilog.
module scan_chain_ctrl #(
  parameter int CHAIN_LEN = 32,
  parameter int CNT_W     = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] pattern,
  input  logic [CHAIN_LEN-1:0] expect_vec,
  input  logic [CHAIN_LEN-1:0] mask,
  input  logic                 scan_out0,
  output logic                 scan_in0,
  output logic                 scan_en,
  output logic                 test_mode,
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] captured,
  output logic                 pass,
  output logic [CNT_W-1:0]     fail_count
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SHIFT_IN  = 3'd1;
  localparam logic [2:0] S_CAPTURE   = 3'd2;
  localparam logic [2:0] S_SHIFT_OUT = 3'd3;
  localparam logic [2:0] S_DONE      = 3'd4;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);

  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CHAIN_LEN-1:0] pat_q, pat_d;
  logic [CHAIN_LEN-1:0] cap_q, cap_d;
  logic                 pass_q, pass_d;

`ifdef SCAN_COMPARE_EN
  logic [CHAIN_LEN-1:0] exp_q, exp_d;
  logic [CHAIN_LEN-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]     fcnt_q, fcnt_d;

  // Mismatch counter never wraps back to zero, so pass cannot be faked by overflow.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
`else
  logic unused_cmp_inputs;
  assign unused_cmp_inputs = ^{expect_vec, mask};
`endif

  // Next-state, counter and datapath: pattern/expect/mask are shifted right so bit 0 is always current.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    cap_d   = cap_q;
    pass_d  = pass_q;
`ifdef SCAN_COMPARE_EN
    exp_d   = exp_q;
    mask_d  = mask_q;
    fcnt_d  = fcnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pat_d   = pattern;
          cnt_d   = '0;
          state_d = S_SHIFT_IN;
`ifdef SCAN_COMPARE_EN
          exp_d   = expect_vec;
          mask_d  = mask;
          fcnt_d  = '0;
`endif
        end
      end
      S_SHIFT_IN: begin
        pat_d = pat_q >> 1;
        if (cnt_q == LAST_BIT) begin
          cnt_d   = '0;
          state_d = S_CAPTURE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CAPTURE: begin
        cnt_d   = '0;
        state_d = S_SHIFT_OUT;
      end
      S_SHIFT_OUT: begin
        // First bit out lands in captured[0] after CHAIN_LEN right-shifts.
        cap_d = {scan_out0, cap_q[CHAIN_LEN-1:1]};
`ifdef SCAN_COMPARE_EN
        exp_d  = exp_q >> 1;
        mask_d = mask_q >> 1;
        if (mask_q[0] && (scan_out0 != exp_q[0])) fcnt_d = sat_inc(fcnt_q);
`endif
        if (cnt_q == LAST_BIT) begin
          cnt_d   = '0;
          state_d = S_DONE;
`ifdef SCAN_COMPARE_EN
          pass_d  = (fcnt_d == '0);
`else
          pass_d  = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control and result registers; reset discards any partial capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cap_q   <= '0;
      pass_q  <= 1'b0;
`ifdef SCAN_COMPARE_EN
      fcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      pass_q  <= pass_d;
`ifdef SCAN_COMPARE_EN
      fcnt_q  <= fcnt_d;
`endif
    end
  end

  // Latched request vectors; only meaningful once a start has been accepted.
  always_ff @(posedge clk) begin
    pat_q  <= pat_d;
`ifdef SCAN_COMPARE_EN
    exp_q  <= exp_d;
    mask_q <= mask_d;
`endif
  end

  assign scan_en    = (state_q == S_SHIFT_IN) || (state_q == S_SHIFT_OUT);
  assign scan_in0   = (state_q == S_SHIFT_IN) && pat_q[0];
  assign busy       = (state_q != S_IDLE);
  assign test_mode  = busy;
  assign done       = (state_q == S_DONE);
  assign captured   = cap_q;
  assign pass       = pass_q;
`ifdef SCAN_COMPARE_EN
  assign fail_count = fcnt_q;
`else
  assign fail_count = '0;
`endif

endmodule
